led_trail_pwm: RTL and testbench

- Sits directly downstream of the one-hot LED scanner: takes its 10-bit LED pattern and drives the board LEDR pins.
- Each LED that has just been lit fades out gradually, producing a glowing "comet tail" behind the moving dot.
- Per-LED brightness registers are reloaded to full whenever the scanner lights that LED, then decremented on a slow decay tick.
- Brightness is rendered by a shared PWM counter.

---
 rtl/led_trail_pwm.sv | 73 +++++++
 tb/tb_led_trail_pwm.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/led_trail_pwm.sv
// rtl/led_trail_pwm.sv - comet-tail LED driver: per-LED brightness reload/decay rendered by a shared PWM counter
module led_trail_pwm #(
  parameter int NUM_LEDS  = 10,
  parameter int PWM_BITS  = 4,
  parameter int DECAY_DIV = 1000000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic                hold,
  output logic [NUM_LEDS-1:0] LEDR
);

  localparam int DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_LAST = MAX - 1'b1;

  logic [NUM_LEDS-1:0] s1_q, s1_d;
  logic [NUM_LEDS-1:0] s2_q, s2_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] bright_q, bright_d;
  logic [NUM_LEDS-1:0] ledr_q, ledr_d;
  logic                tick;

  assign LEDR = ledr_q;

  always_comb begin
    // led_in comes from a divided clock domain, so it is double-registered
    s1_d = led_in;
    s2_d = s1_q;

    tick  = (div_q == DIV_LAST) && !hold;
    div_d = div_q;
    if (!hold) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;

    bright_d = bright_q;
    ledr_d   = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      // a lit LED reloads every cycle, so it wins over a coincident tick
      if (s2_q[i]) begin
        bright_d[i] = MAX;
      end else if (tick && (bright_q[i] != '0)) begin
        bright_d[i] = bright_q[i] - 1'b1;
      end
      ledr_d[i] = (bright_q[i] > pwm_cnt_q);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      div_q     <= '0;
      pwm_cnt_q <= '0;
      bright_q  <= '0;
      ledr_q    <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      div_q     <= div_d;
      pwm_cnt_q <= pwm_cnt_d;
      bright_q  <= bright_d;
      ledr_q    <= ledr_d;
    end
  end

endmodule

// File: tb/tb_led_trail_pwm.sv
// tb/tb_led_trail_pwm.sv - directed self-checking bench for led_trail_pwm (DECAY_DIV=4, PWM_BITS=4)
module tb_led_trail_pwm;

  localparam int N = 10;

  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic         hold;
  logic [N-1:0] led_in;
  logic [N-1:0] LEDR;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  int hi;
  int ok;
  int pos;
  int last_visit [N];

  always #5 CLOCK_50 = ~CLOCK_50;

  led_trail_pwm #(
    .NUM_LEDS (N),
    .PWM_BITS (4),
    .DECAY_DIV(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .led_in  (led_in),
    .hold    (hold),
    .LEDR    (LEDR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
    edge_n++;
  endtask

  // Pulse reset between edges and confirm everything clears before the next edge.
  task automatic do_reset();
    #4;
    reset = 1'b1;
    #1;
    chk("rst_async_ledr", 32'(LEDR), 0);
    chk("rst_bright", 32'(|dut.bright_q), 0);
    chk("rst_pwm", 32'(dut.pwm_cnt_q), 0);
    chk("rst_div", 32'(dut.div_q), 0);
    chk("rst_sync", 32'({dut.s1_q, dut.s2_q}), 0);
    @(posedge CLOCK_50);
    #1;
    reset  = 1'b0;
    edge_n = 0;
  endtask

  // Expected brightness after edge k when the LED is lit before edge 1 and dropped after edge 8.
  function automatic int eb(int k);
    int v;
    if (k < 3) return 0;
    if (k < 12) return 15;
    v = 15 - (k - 8) / 4;
    return (v < 0) ? 0 : v;
  endfunction

  initial begin
    reset  = 1'b1;
    hold   = 1'b0;
    led_in = '0;
    step();
    step();
    chk("init_ledr", 32'(LEDR), 0);
    chk("init_bright", 32'(|dut.bright_q), 0);
    reset  = 1'b0;
    edge_n = 0;

    // 1: reset in the middle of lit and fading tails
    led_in = '1;
    repeat (6) step();
    chk("t1_all_lit", 32'(LEDR), 32'h3FF);
    led_in = '0;
    repeat (10) step();
    chk("t1_fading_ledr", 32'(LEDR), 32'h3FF);
    chk("t1_fading_bright0", 32'(dut.bright_q[0]), 13);
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      step();
      chk("t1_post_reset_dark", 32'(LEDR), 0);
    end

    // 2: latency and full-on
    do_reset();
    led_in = 10'h001;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("t2_latency", 32'(LEDR), (k >= 4) ? 32'h001 : 32'h000);
    end

    // 3: decay staircase and saturation at zero
    do_reset();
    led_in = 10'h001;
    for (int k = 1; k <= 150; k++) begin
      step();
      if (k == 8) led_in = '0;
      chk("t3_ledr0", 32'(LEDR[0]), 32'(eb(k - 1) > ((k - 1) % 15)));
      chk("t3_others", 32'(LEDR[N-1:1]), 0);
      if (k % 4 == 0) chk("t3_bright0", 32'(dut.bright_q[0]), 32'(eb(k)));
    end

    // 4: reload wins over tick
    do_reset();
    led_in = 10'h008;
    for (int k = 1; k <= 60; k++) begin
      step();
      chk("t4_bright3", 32'(dut.bright_q[3]), (k >= 3) ? 15 : 0);
      chk("t4_ledr", 32'(LEDR), (k >= 4) ? 32'h008 : 32'h000);
    end

    // 5: hold freezes decay at bright=7
    do_reset();
    led_in = 10'h020;
    for (int k = 1; k <= 41; k++) begin
      step();
      if (k == 8) led_in = '0;
    end
    chk("t5_bright_pre_hold", 32'(dut.bright_q[5]), 7);
    hold = 1'b1;
    hi   = 0;
    for (int k = 42; k <= 141; k++) begin
      step();
      chk("t5_ledr5_hold", 32'(LEDR[5]), 32'(7 > ((k - 1) % 15)));
      if (k >= 45 && k < 135) begin
        hi += int'(LEDR[5]);
        if ((k - 45) % 15 == 14) begin
          chk("t5_duty", 32'(hi), 7);
          hi = 0;
        end
      end
    end
    chk("t5_bright_held", 32'(dut.bright_q[5]), 7);
    chk("t5_div_frozen", 32'(dut.div_q), 1);
    hold = 1'b0;
    step();
    step();
    chk("t5_bright_before_tick", 32'(dut.bright_q[5]), 7);
    step();
    chk("t5_bright_after_tick", 32'(dut.bright_q[5]), 6);

    // 6: scanner sweep 0->9->0, one step per 8 cycles
    do_reset();
    for (int i = 0; i < N; i++) last_visit[i] = -1;
    for (int s = 0; s <= 18; s++) begin
      pos             = (s <= 9) ? s : 18 - s;
      led_in          = 10'(1 << pos);
      last_visit[pos] = s;
      repeat (8) step();
      chk("t6_dot_bright", 32'(dut.bright_q[pos]), 15);
      chk("t6_dot_ledr", 32'(LEDR[pos]), 1);
      ok = 1;
      for (int i = 0; i < N; i++) begin
        if (last_visit[i] < 0 && dut.bright_q[i] != 4'd0) ok = 0;
        for (int j = 0; j < N; j++) begin
          if (last_visit[i] > last_visit[j] && dut.bright_q[i] < dut.bright_q[j]) ok = 0;
        end
      end
      chk("t6_trail_order", 32'(ok), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
